// File: rtl/uart_tx_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_param
// Brief    : UART transmitter with FIFO, none/even/odd parity, 1/2 stop bits.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo_param #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tx_en,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_two_stop,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic                          ovf_clr,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic                          ovf
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W  = c_ADDR_W + 1;
    localparam int c_IDX_W  = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and pointers
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic                r_ovf;

    // Frame registers
    state_t              r_state;
    logic [DATA_W-1:0]   r_word;
    logic [DATA_W-1:0]   r_shift;
    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    r_baud;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_par_en;
    logic                r_par_odd;
    logic                r_two_stop;
    logic                r_stop_cnt;
    logic                r_tx;
    logic                r_busy;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_can_start;
    logic                w_bit_done;
    logic                w_frame_end;
    logic [DATA_W-1:0]   w_head;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == c_LVL_W'(FIFO_DEPTH));
    assign w_push      = wr_valid && !w_full;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_can_start = tx_en && !w_empty && (cfg_div != '0);
    assign w_bit_done  = (r_baud == (r_div - DIV_W'(1)));
    assign w_frame_end = (r_state == S_STOP) && w_bit_done && (r_stop_cnt == r_two_stop);
    // Next frame may start straight out of the last stop period: no idle gap
    assign w_pop       = w_can_start && ((r_state == S_IDLE) || w_frame_end);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
            // A new overflow takes priority over a clear in the same cycle
            if (wr_valid && w_full) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= S_IDLE;
            r_word     <= '0;
            r_shift    <= '0;
            r_div      <= '0;
            r_baud     <= '0;
            r_idx      <= '0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_two_stop <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else if (w_pop) begin
            r_state    <= S_START;
            r_word     <= w_head;
            r_shift    <= w_head;
            r_div      <= cfg_div;
            r_baud     <= '0;
            r_idx      <= '0;
            r_par_en   <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            r_par_odd  <= (cfg_parity == 2'b10);
            r_two_stop <= cfg_two_stop;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            if (r_state != S_IDLE) begin
                r_baud <= w_bit_done ? '0 : r_baud + DIV_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_state <= S_DATA;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        if (r_idx == c_IDX_W'(DATA_W - 1)) begin
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                r_tx    <= (^r_word) ^ r_par_odd;
                            end else begin
                                r_state    <= S_STOP;
                                r_tx       <= 1'b1;
                                r_stop_cnt <= 1'b0;
                            end
                        end else begin
                            r_idx   <= r_idx + c_IDX_W'(1);
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_state    <= S_STOP;
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        if (r_stop_cnt == r_two_stop) begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready   = !w_full;
    assign tx_out     = r_tx;
    assign busy       = r_busy;
    assign fifo_level = r_level;
    assign fifo_empty = w_empty;
    assign fifo_full  = w_full;
    assign ovf        = r_ovf;

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
Parametrised second-generation UART transmitter with a configurable-depth transmit FIFO, a runtime-selectable parity mode (none/even/odd), one or two stop bits, and a configurable data width. It sits behind the peripheral register decoder. Words are pushed through a valid/ready interface, and the block serialises them LSB-first on tx_out with back-to-back frames and no idle gap. Status outputs (level, full/empty, busy, sticky overflow) feed the status register.

Parameters:
DATA_W, 8, data bits per frame (5..9)
FIFO_DEPTH, 8, transmit FIFO entries (power of 2, >=2)
DIV_W, 16, width of baud divisor

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-high
tx_en  in  1  transmitter enable
cfg_div  in  DIV_W  clk cycles per bit; 0 = transmitter halted
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none
cfg_two_stop  in  1  1 = two stop bits
wr_data  in  DATA_W  word to transmit
wr_valid  in  1  push request
wr_ready  out  1  FIFO can accept (= !fifo_full)
ovf_clr  in  1  clears ovf
tx_out  out  1  serial line, registered, idle high
busy  out  1  frame in progress
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
fifo_empty  out  1  level == 0
fifo_full  out  1  level == FIFO_DEPTH
ovf  out  1  sticky: wr_valid seen while full

Behaviour:
- Reset (async, rst_n=1): tx_out=1, busy=0, fifo_level=0, fifo_empty=1, fifo_full=0, wr_ready=1, ovf=0, FSM=IDLE, counters=0. A reset mid-frame aborts the frame immediately, and the FIFO contents are discarded.
- Push: a word is accepted on the edge where wr_valid && wr_ready. A push while full is dropped and sets ovf. ovf_clr clears ovf; if ovf_clr and a new overflow occur in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop changes level by 0. A push while full is never accepted, even if a pop occurs in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1, busy=0. When tx_en && !fifo_empty && cfg_div!=0:
  - pop the head word;
  - latch the word, cfg_div, cfg_parity and cfg_two_stop into frame registers;
  - go to START.
  Config changes mid-frame have no effect until the next frame.
- Latency: a word pushed into an empty FIFO with IDLE state pops on the next edge. tx_out falls at that pop edge, so the start bit begins 1 cycle after the push edge.
- Every bit period lasts exactly div_r clk cycles. The baud counter runs 0..div_r-1 and produces a bit_done pulse at div_r-1, then wraps to 0.
- START: tx_out=0 for one bit period, then DATA.
- DATA: DATA_W bits, LSB first; the bit index counter runs 0..DATA_W-1.
  - After the last bit: go to PARITY if parity is enabled, else STOP.
- PARITY: even mode sends XOR of the data bits; odd mode sends its inverse.
- STOP: tx_out=1 for 1 or 2 bit periods, per the latched stop setting.
- At the end of the final stop period:
  - if tx_en && !fifo_empty && cfg_div!=0: pop and enter START on the same edge (zero idle gap);
  - else go to IDLE.
- tx_en deassertion mid-frame: the current frame completes; no further pops occur.
- cfg_div=0 while in IDLE: no pop. busy=1 in every state except IDLE.
- Frame length in clk cycles = div_r × (1 + DATA_W + parity_en + stop_bits).

Test Plan:
1. DATA_W=8, div=4, parity none, 1 stop; push 0xA5 → tx_out starts 1 cycle after push and carries 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; 40 cycles total; busy high for 40 cycles; fifo_level returns 0 at the pop edge.
2. div=2, even parity, 2 stops; push 0x03 → parity bit 0, two high stop periods, frame 24 cycles. Repeat with odd parity → parity bit 1.
3. DEPTH=4, tx_en=0; push 5 consecutive words:
   - wr_ready=0 after the 4th push; fifo_level=4, fifo_full=1;
   - the 5th wr_valid sets ovf=1;
   - ovf_clr pulse → ovf=0.
4. tx_en=1, div=3; push 0x11, 0x22, 0x33 back-to-back → three contiguous 30-cycle frames. Each start bit begins on the cycle right after the previous stop period, with no idle cycle. busy stays high for 90 cycles.
5. Mid-frame, change cfg_div 4→8 and cfg_parity none→odd → the current frame is unchanged; the next frame uses div 8 with an odd parity bit.
6. Assert rst_n during the DATA state → tx_out=1 and fifo_level=0 immediately (asynchronous). After release, no transmission occurs until a new push.
